// File: rtl/axis_burst_drain_pkg.sv
// axis_burst_drain_pkg: shared FSM state type and default sizing for the burst drain block
package axis_burst_drain_pkg;
  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_e;
  localparam int unsigned DEF_TDATA_WIDTH = 128;
  localparam int unsigned DEF_BURST_LEN   = 16;
endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: single-entry AXI-Stream output register holding data and TLAST until the sink takes it
// Ports: clk_i/rst_ni clock and async active-low reset; load_i captures data_i/last_i;
//        ready_i is the sink's TREADY; valid_o/data_o/last_o drive the M-side beat.
module axis_out_reg #(
  parameter int unsigned TDATA_WIDTH = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic [TDATA_WIDTH-1:0] data_i,
  input  logic                   last_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [TDATA_WIDTH-1:0] data_o,
  output logic                   last_o
);
  logic                   valid_q, valid_d, last_q, last_d;
  logic [TDATA_WIDTH-1:0] data_q, data_d;
  always_comb begin
    valid_d = load_i ? 1'b1 : (valid_q && ready_i) ? 1'b0 : valid_q;
    data_d  = load_i ? data_i : data_q;
    last_d  = load_i ? last_i : last_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
endmodule

// File: rtl/axis_burst_drain.sv
// axis_burst_drain: drains a FIFO in fixed-length AXI-Stream bursts, with flush for partial bursts
// Ports: aclk/aresetn clock and async active-low reset; S_AXIS_* FIFO side with fifo_count occupancy;
//        flush pulse requests a partial burst; M_AXIS_* burst output; busy, beats_sent, bursts_sent status.
module axis_burst_drain import axis_burst_drain_pkg::*; #(
  parameter int unsigned TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned CNT_W       = $clog2(BURST_LEN) + 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  input  logic [31:0]            fifo_count,
  input  logic                   flush,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  output logic                   M_AXIS_TLAST,
  input  logic                   M_AXIS_TREADY,
  output logic                   busy,
  output logic [31:0]            beats_sent,
  output logic [31:0]            bursts_sent
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             fp_q, fp_d, fp_clr, s_hs, m_hs;
  logic [31:0]      beats_q, beats_d, bursts_q, bursts_d;
  // A held output beat only blocks intake if the sink is not taking it this cycle.
  assign S_AXIS_TREADY = (state_q != IDLE) && (rem_q != '0) && (!M_AXIS_TVALID || M_AXIS_TREADY);
  assign s_hs = S_AXIS_TVALID && S_AXIS_TREADY;
  assign m_hs = M_AXIS_TVALID && M_AXIS_TREADY;
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fp_clr  = 1'b0;
    if (state_q == IDLE) begin
      // A full burst takes priority; a pending flush survives it and is served afterwards.
      if (fifo_count >= 32'(BURST_LEN)) begin
        state_d = BURST;
        rem_d   = CNT_W'(BURST_LEN);
      end else if (fp_q) begin
        fp_clr = 1'b1;
        if (fifo_count != '0) begin
          state_d = FLUSH;
          rem_d   = fifo_count[CNT_W-1:0];
        end
      end
    end else if (s_hs) begin
      rem_d = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) state_d = IDLE;
    end
    fp_d     = flush || (fp_q && !fp_clr);
    beats_d  = beats_q + 32'(m_hs);
    bursts_d = bursts_q + 32'(m_hs && M_AXIS_TLAST);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      fp_q     <= 1'b0;
      beats_q  <= '0;
      bursts_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      fp_q     <= fp_d;
      beats_q  <= beats_d;
      bursts_q <= bursts_d;
    end
  end
  axis_out_reg #(.TDATA_WIDTH(TDATA_WIDTH)) u_out (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .load_i  (s_hs),
    .data_i  (S_AXIS_TDATA),
    .last_i  (rem_q == CNT_W'(1)),
    .ready_i (M_AXIS_TREADY),
    .valid_o (M_AXIS_TVALID),
    .data_o  (M_AXIS_TDATA),
    .last_o  (M_AXIS_TLAST)
  );
  assign busy        = (state_q != IDLE) || M_AXIS_TVALID;
  assign beats_sent  = beats_q;
  assign bursts_sent = bursts_q;
endmodule

// File: tb/tb_axis_burst_drain.sv
// tb_axis_burst_drain: directed self-checking bench for axis_burst_drain
module tb_axis_burst_drain;
  localparam int W = 32;
  logic          aclk = 1'b0, aresetn = 1'b0;
  logic [W-1:0]  S_AXIS_TDATA = '0, M_AXIS_TDATA;
  logic          S_AXIS_TVALID = 1'b0, S_AXIS_TREADY;
  logic [31:0]   fifo_count = '0, beats_sent, bursts_sent;
  logic          flush = 1'b0, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY = 1'b1, busy;
  axis_burst_drain #(.TDATA_WIDTH(W), .BURST_LEN(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .fifo_count(fifo_count), .flush(flush),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY), .busy(busy), .beats_sent(beats_sent), .bursts_sent(bursts_sent)
  );
  always #5 aclk = ~aclk;
  int n_cmp = 0, n_err = 0, cyc = 0, mode = 0;
  logic [W-1:0] src_q[$], out_d[$];
  logic out_l[$];
  int out_c[$];
  bit s_hs = 0, flush_req = 0, tog = 0, chk_stab = 0, chk_idle = 0;
  bit p_hold = 0, p_last = 0;
  logic [W-1:0] p_data = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One clock: retire last cycle's S handshake, drive new inputs, then sample mid-cycle.
  task automatic cycle();
    @(posedge aclk);
    #2;
    if (s_hs) void'(src_q.pop_front());
    flush = flush_req;
    flush_req = 0;
    S_AXIS_TVALID = src_q.size() > 0;
    S_AXIS_TDATA = src_q.size() > 0 ? src_q[0] : '0;
    fifo_count = 32'(src_q.size());
    M_AXIS_TREADY = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'b0;
    tog = ~tog;
    #2;
    if (chk_stab && p_hold) begin
      chk("stall_valid", 64'(M_AXIS_TVALID), 64'd1);
      chk("stall_data", 64'(M_AXIS_TDATA), 64'(p_data));
      chk("stall_last", 64'(M_AXIS_TLAST), 64'(p_last));
    end
    if (chk_stab && M_AXIS_TVALID && !M_AXIS_TREADY) chk("stall_sready", 64'(S_AXIS_TREADY), 64'd0);
    if (chk_idle) begin
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    end
    p_hold = M_AXIS_TVALID && !M_AXIS_TREADY;
    p_data = M_AXIS_TDATA;
    p_last = M_AXIS_TLAST;
    s_hs = S_AXIS_TVALID && S_AXIS_TREADY;
    if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      out_d.push_back(M_AXIS_TDATA);
      out_l.push_back(M_AXIS_TLAST);
      out_c.push_back(cyc);
    end
    cyc++;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic push(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(base + W'(i));
  endtask
  // Expect n1 beats then n2 beats of consecutive data from base, TLAST ending each burst.
  task automatic check_out(input string tag, input logic [W-1:0] base, input int n1, input int n2);
    chk({tag, "_nbeats"}, 64'(out_d.size()), 64'(n1 + n2));
    for (int i = 0; i < out_d.size() && i < n1 + n2; i++) begin
      chk({tag, "_data"}, 64'(out_d[i]), 64'(base + W'(i)));
      chk({tag, "_last"}, 64'(out_l[i]), 64'((i == n1 - 1) || (i == n1 + n2 - 1)));
    end
  endtask
  task automatic clear_out();
    out_d.delete();
    out_l.delete();
    out_c.delete();
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mvalid"}, 64'(M_AXIS_TVALID), 64'd0);
    chk({tag, "_mlast"}, 64'(M_AXIS_TLAST), 64'd0);
    chk({tag, "_mdata"}, 64'(M_AXIS_TDATA), 64'd0);
    chk({tag, "_sready"}, 64'(S_AXIS_TREADY), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_beats"}, 64'(beats_sent), 64'd0);
    chk({tag, "_bursts"}, 64'(bursts_sent), 64'd0);
  endtask
  logic [31:0] b0, k0;
  initial begin
    run(3);
    check_reset_outputs("rst");
    aresetn = 1'b1;
    run(2);
    // Full burst, sink always ready: 16 back-to-back beats.
    push(32'h0A00, 16);
    run(25);
    check_out("full", 32'h0A00, 16, 0);
    if (out_c.size() == 16) chk("full_thru", 64'(out_c[15] - out_c[0]), 64'd15);
    chk("full_beats", 64'(beats_sent), 64'd16);
    chk("full_bursts", 64'(bursts_sent), 64'd1);
    chk("full_idle_busy", 64'(busy), 64'd0);
    clear_out();
    // Flush of a 5-beat partial burst, then no further bursts from later data.
    push(32'h0B00, 5);
    flush_req = 1;
    run(15);
    check_out("flush5", 32'h0B00, 5, 0);
    chk("flush5_bursts", 64'(bursts_sent), 64'd2);
    clear_out();
    push(32'h0B80, 3);
    run(10);
    chk("flush_cleared", 64'(out_d.size()), 64'd0);
    src_q.delete();
    s_hs = 0;
    run(2);
    // Sink toggling ready: order and TLAST intact, outputs stable on stalls.
    mode = 1;
    chk_stab = 1;
    push(32'h0C00, 16);
    run(45);
    chk_stab = 0;
    mode = 0;
    check_out("toggle", 32'h0C00, 16, 0);
    clear_out();
    // Full burst and pending flush together: 16 beats, one decision cycle, then 4.
    b0 = bursts_sent;
    push(32'h0D00, 20);
    flush_req = 1;
    run(35);
    check_out("both", 32'h0D00, 16, 4);
    if (out_c.size() == 20) chk("both_gap", 64'(out_c[16] - out_c[15]), 64'd2);
    chk("both_bursts", 64'(bursts_sent - b0), 64'd2);
    clear_out();
    // Flush with empty FIFO: nothing emitted, never busy.
    chk_idle = 1;
    flush_req = 1;
    run(6);
    chk_idle = 0;
    chk("empty_flush_nbeats", 64'(out_d.size()), 64'd0);
    push(32'h0E80, 3);
    run(8);
    chk("empty_flush_cleared", 64'(out_d.size()), 64'd0);
    src_q.delete();
    s_hs = 0;
    run(2);
    // Reset after beat 7 of 16, then a clean new burst.
    k0 = beats_sent;
    push(32'h0E00, 16);
    for (int i = 0; i < 60 && out_d.size() < 7; i++) cycle();
    chk("rst_reach7", 64'(out_d.size()), 64'd7);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    src_q.delete();
    s_hs = 0;
    clear_out();
    run(2);
    aresetn = 1'b1;
    run(2);
    push(32'h0F00, 16);
    run(25);
    check_out("postrst", 32'h0F00, 16, 0);
    chk("postrst_beats", 64'(beats_sent), 64'd16);
    chk("postrst_bursts", 64'(bursts_sent), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
